// File: rtl/decode_pkg.sv
// Shared instruction-field layout, widths and opcode constants for the decode stage.
package decode_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned IMM_W      = 6;
  localparam int unsigned OPC_W      = 4;
  localparam int unsigned FUNCT_W    = 3;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 12;
  localparam int unsigned RS_MSB    = 11;
  localparam int unsigned RS_LSB    = 9;
  localparam int unsigned RT_MSB    = 8;
  localparam int unsigned RT_LSB    = 6;
  localparam int unsigned RD_MSB    = 5;
  localparam int unsigned RD_LSB    = 3;
  localparam int unsigned FUNCT_MSB = 2;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 5;
  localparam int unsigned IMM_LSB   = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_ALU   = 4'h0,
    OP_ADDI  = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3
  } opcode_e;

  localparam logic [OPC_W-1:0] LOAD_OPCODE_DEFAULT = OP_LOAD;

  // Register-index and control fields of one instruction word.
  typedef struct packed {
    logic [OPC_W-1:0]      opc;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [FUNCT_W-1:0]    funct;
  } instr_fields_t;

  function automatic instr_fields_t splitFields(input logic [INSTR_W-1:0] instr);
    instr_fields_t f;
    f.opc   = instr[OPC_MSB:OPC_LSB];
    f.rs    = instr[RS_MSB:RS_LSB];
    f.rt    = instr[RT_MSB:RT_LSB];
    f.rd    = instr[RD_MSB:RD_LSB];
    f.funct = instr[FUNCT_MSB:FUNCT_LSB];
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_reg_bank.sv
// 8-entry register bank: two combinational read ports, one synchronous write port,
// R0 reads as zero and ignores writes.
module reg_bank
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [REG_ADDR_W-1:0] readAddr1,
  input  logic [REG_ADDR_W-1:0] readAddr2,
  input  logic                  writeEn,
  input  logic [REG_ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0]     writeData,
  output logic [DATA_W-1:0]     readData1_c,
  output logic [DATA_W-1:0]     readData2_c
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (writeEn && (writeAddr != '0)) begin
      regs[writeAddr] <= writeData;
    end
  end

  assign readData1_c = (readAddr1 == '0) ? '0 : regs[readAddr1];
  assign readData2_c = (readAddr2 == '0) ? '0 : regs[readAddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register bank, sign extension, load-use stall and ID/EX register
// with valid/ready handshakes. Define DECODE_BYPASS_EN to forward same-cycle write-back data.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned      DATA_W      = 16,
  parameter logic [OPC_W-1:0] LOAD_OPCODE = LOAD_OPCODE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  RegDst,
  input  logic                  flush,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0]     dataToWrite,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_W-1:0]     readData1,
  output logic [DATA_W-1:0]     readData2,
  output logic [DATA_W-1:0]     extendedSignal,
  output logic [REG_ADDR_W-1:0] destReg,
  output logic [OPC_W-1:0]      opcode,
  output logic [FUNCT_W-1:0]    funct
);

  instr_fields_t         fields_c;
  logic [DATA_W-1:0]     bankRd1_c, bankRd2_c;
  logic [DATA_W-1:0]     opA_c, opB_c, immExt_c;
  logic [REG_ADDR_W-1:0] destSel_c;
  logic                  hazard_c, advance_c, accept_c;

  assign fields_c = splitFields(instruction);

  reg_bank #(.DATA_W(DATA_W)) uRegBank (
    .clock       (clock),
    .resetN      (resetN),
    .readAddr1   (fields_c.rs),
    .readAddr2   (fields_c.rt),
    .writeEn     (RegWrite),
    .writeAddr   (writeAddr),
    .writeData   (dataToWrite),
    .readData1_c (bankRd1_c),
    .readData2_c (bankRd2_c)
  );

`ifdef DECODE_BYPASS_EN
  // Same-cycle write-back wins over the bank's not-yet-updated contents.
  assign opA_c = (RegWrite && (writeAddr != '0) && (writeAddr == fields_c.rs)) ? dataToWrite : bankRd1_c;
  assign opB_c = (RegWrite && (writeAddr != '0) && (writeAddr == fields_c.rt)) ? dataToWrite : bankRd2_c;
`else
  assign opA_c = bankRd1_c;
  assign opB_c = bankRd2_c;
`endif

  assign immExt_c  = {{(DATA_W-IMM_W){instruction[IMM_MSB]}}, instruction[IMM_MSB:IMM_LSB]};
  assign destSel_c = RegDst ? fields_c.rd : fields_c.rt;

  // A load still in ID/EX cannot supply its result to an instruction decoding now.
  assign hazard_c  = inValid && outValid && (opcode == LOAD_OPCODE) && (destReg != '0) &&
                     ((destReg == fields_c.rs) || (destReg == fields_c.rt));
  assign advance_c = !outValid || outReady;
  assign accept_c  = advance_c && inValid && !hazard_c;
  assign inReady   = resetN && (flush || (advance_c && !hazard_c));

  // ID/EX register: flush drops everything, a stall or empty input leaves a bubble.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      outValid       <= 1'b0;
      readData1      <= '0;
      readData2      <= '0;
      extendedSignal <= '0;
      destReg        <= '0;
      opcode         <= '0;
      funct          <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (accept_c) begin
      outValid       <= 1'b1;
      readData1      <= opA_c;
      readData2      <= opB_c;
      extendedSignal <= immExt_c;
      destReg        <= destSel_c;
      opcode         <= fields_c.opc;
      funct          <= fields_c.funct;
    end else if (advance_c) begin
      outValid <= 1'b0;
    end
  end

endmodule
